irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

- Captures three raw request lines into sticky pending flags and applies a per-channel mask.
- Presents the masked pending vector directly to the downstream 3-bit priority encoder; bit 2 is highest priority.
- Accepts an acknowledge carrying the encoder's 2-bit code, clears the serviced channel, and enforces a per-channel re-arm hold-off.
- Records overrun when a request cannot be captured.

## Interface
- HOLDOFF, default 4: re-arm hold-off in cycles after an accepted ack; 0 disables hold-off.
- HO_W, default 4: hold-off counter width; HOLDOFF must be ≤ 2^HO_W−1.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  3  raw request lines; bit n belongs to channel n.
- mask_i  in  3  1 = channel masked from pend_o. The pending flag is kept.
- pend_o  out  3  masked pending vector; feeds the encoder's data_in_i.
- pend_valid_o  out  1  OR of pend_o.
- ack_i  in  1  acknowledge strobe, one cycle per service.
- ack_code_i  in  2  encoder code of the serviced channel: 2'b11=ch2, 2'b10=ch1, 2'b01=ch0, 2'b00=none.
- overrun_o  out  3  sticky per-channel overrun flags.
- ovr_clr_i  in  1  clears all overrun flags.

## Operation
- State per channel: pending bit, hold-off counter, overrun bit, previous-request register req_q.
- Event on channel n:
  - Edge mode: req_i[n] & ~req_q[n].
  - Level mode: req_i[n].
- Capture: on an event, if pending[n]=0 and holdoff[n]=0, set pending[n].
- Overrun, edge mode: an event while pending[n]=1, or while holdoff[n]≠0, sets overrun[n]. The event is dropped.
- Overrun, level mode: never set by a held level. Only the coincident ack/event case sets it.
- Ack handling: ack_i=1 with ack_code_i=k≠0 targets channel k−1.
  - If that channel is pending: clear pending and load holdoff with HOLDOFF.
  - Ack for a non-pending channel: no effect, no hold-off load.
  - ack_code_i=0, or ack_i=0: no effect.
- Hold-off counter decrements by 1 per cycle while nonzero and saturates at 0.
- Same-cycle ack and event on the same channel: ack wins. pending clears, holdoff loads, and the event is dropped.
  - Edge mode: the dropped event sets overrun.
- Masking: pend_o = pending & ~mask_i, combinational from registered pending and mask_i. A masked channel keeps its pending bit and reappears when unmasked.
- Overrun clear: ovr_clr_i clears all overrun bits. A new overrun in the same cycle wins and that bit stays set.
- Channel priority is resolved downstream, not in this block.

## Timing
- Reset values: pending, holdoff, overrun and req_q all 0. Therefore pend_o=3'b000, pend_valid_o=0, overrun_o=3'b000.
- Edge mode: a request already high when reset releases is seen as an edge on the first cycle.
- Reset mid-operation discards all pending, hold-off and overrun state in that cycle.
- Capture latency: event sampled at edge N gives pend_o[n]=1 after edge N (one cycle).
- Mask latency: zero cycles (combinational).
- Ack latency: ack sampled at edge N gives pend_o[n]=0 after edge N.
- Re-arm latency: with HOLDOFF=H, the earliest re-capture is an event sampled at edge N+H+1.
- All three channels capture independently in the same cycle.

## Configuration
- IRQ_EDGE_DET_EN defined: edge mode. req_q is instantiated and requests are rising-edge detected.
- IRQ_EDGE_DET_EN undefined: level mode. req_q is removed, and a level held through hold-off is captured again when hold-off expires.

## Structure
- Package irq_pkg holds:
  - NUM_CH=3.
  - Code constants CODE_NONE, CODE_CH0, CODE_CH1, CODE_CH2.
  - Function code_to_onehot(2-bit) returning a 3-bit one-hot with 0 for CODE_NONE.
  - Default HOLDOFF and HO_W.
- Sub-module irq_holdoff_cnt: load/decrement/zero-flag counter, instantiated once per channel.

## Test plan
- Reset, then req_i=3'b101 pulse for one cycle: pend_o=3'b101 one cycle later; pend_valid_o=1; overrun_o=0.
- pend_o=3'b100, ack_i=1, ack_code_i=2'b11, HOLDOFF=4: pend_o=3'b000. A req_i[2] pulse 3 cycles later is dropped and overrun_o=3'b100 (edge mode). A pulse 5 cycles after the ack is captured.
- mask_i=3'b010 with ch1 pending: pend_o=3'b000 and pend_valid_o=0. Set mask_i=0: pend_o=3'b010 in the same cycle.
- ack_code_i=2'b01 while ch0 is not pending: no state change and no hold-off load. A ch0 event the next cycle is captured.
- Same-cycle ack_code_i=2'b10 and req_i[1] rising edge: pend_o[1]=0 and overrun_o[1]=1. Then ovr_clr_i for one cycle: overrun_o=0.
- rst_i asserted for one cycle with pend_o=3'b111 and hold-off active: next cycle all outputs are 0 and an immediate new event is captured.

Source files
------------

// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared constants and helpers for the interrupt pending latch.
//   NUM_CH         : number of request channels
//   CODE_*         : encoder codes carried on an acknowledge
//   HOLDOFF_DEF    : default re-arm hold-off in cycles
//   HO_W_DEF       : default hold-off counter width
//   code_to_onehot : maps an encoder code to a channel one-hot (0 for none)
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int NUM_CH = 3;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_CH0  = 2'b01;
  localparam logic [1:0] CODE_CH1  = 2'b10;
  localparam logic [1:0] CODE_CH2  = 2'b11;

  localparam int HOLDOFF_DEF = 4;
  localparam int HO_W_DEF    = 4;

  // The encoder reserves code 0 for "nothing pending", so channel n is
  // reported as code n+1; undo that offset here.
  function automatic ch_vec_t code_to_onehot(input logic [1:0] code);
    ch_vec_t oh;
    oh = '0;
    case (code)
      CODE_CH0: oh = 3'b001;
      CODE_CH1: oh = 3'b010;
      CODE_CH2: oh = 3'b100;
      CODE_NONE: oh = 3'b000;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/irq_holdoff_cnt.sv
// ---------------------------------------------------------------------------
// irq_holdoff_cnt
// Per-channel re-arm hold-off counter. Loads HOLDOFF when a service is
// accepted, then counts down to zero and stays there.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (counter to 0)
//   load_i : load HOLDOFF this cycle (takes precedence over counting)
//   zero_o : counter is zero, i.e. the channel may capture again
// ---------------------------------------------------------------------------
module irq_holdoff_cnt #(
  parameter int HO_W    = 4,
  parameter int HOLDOFF = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic zero_o
);

  logic [HO_W-1:0] cnt_q;
  logic [HO_W-1:0] cnt_d;

  // Next count: a fresh load restarts the window, otherwise count down and
  // saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = HO_W'(HOLDOFF);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - HO_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/irq_pending_latch.sv
// ---------------------------------------------------------------------------
// irq_pending_latch
// Captures three raw request lines into sticky pending flags, masks them
// towards the downstream priority encoder, clears a channel on acknowledge
// and holds it off from re-arming for HOLDOFF cycles. Requests that cannot
// be captured are recorded as sticky overrun flags.
//
// Build option: define IRQ_EDGE_DET_EN for rising-edge request detection;
// leave it undefined for level-sensitive requests.
//
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   req_i[2:0]   : raw request lines, bit n = channel n
//   mask_i[2:0]  : 1 hides the channel from pend_o (pending bit is kept)
//   pend_o[2:0]  : masked pending vector to the encoder
//   pend_valid_o : any bit of pend_o set
//   ack_i        : acknowledge strobe
//   ack_code_i   : encoder code of the serviced channel (0 = none)
//   overrun_o    : sticky per-channel overrun flags
//   ovr_clr_i    : clears all overrun flags
// ---------------------------------------------------------------------------
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int HOLDOFF = HOLDOFF_DEF,
  parameter int HO_W    = HO_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [NUM_CH-1:0]    mask_i,
  output logic [NUM_CH-1:0]    pend_o,
  output logic                 pend_valid_o,
  input  logic                 ack_i,
  input  logic [1:0]           ack_code_i,
  output logic [NUM_CH-1:0]    overrun_o,
  input  logic                 ovr_clr_i
);

  ch_vec_t pending_q, pending_d;
  ch_vec_t overrun_q, overrun_d;
  ch_vec_t req_event;
  ch_vec_t ack_hit;
  ch_vec_t ovr_set;
  ch_vec_t ho_zero;

  // An acknowledge only counts for a channel that is actually pending;
  // acks for idle channels leave everything untouched.
  assign ack_hit = code_to_onehot(ack_code_i) & {NUM_CH{ack_i}} & pending_q;

`ifdef IRQ_EDGE_DET_EN
  ch_vec_t req_q;

  // Previous request sample for rising-edge detection. Clearing it on reset
  // makes a line that is already high at release look like a fresh edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= '0;
    end else begin
      req_q <= req_i;
    end
  end

  assign req_event = req_i & ~req_q;
  // Any edge that is not captured is lost: already pending (which also
  // covers the coincident-ack case) or still inside the hold-off window.
  assign ovr_set   = req_event & (pending_q | ~ho_zero);
`else
  assign req_event = req_i;
  // A held level is simply retried next cycle, so only the ack that swallows
  // a coincident request counts as lost.
  assign ovr_set   = req_event & ack_hit;
`endif

  // One hold-off counter per channel, loaded by an accepted acknowledge.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_holdoff
    irq_holdoff_cnt #(
      .HO_W    (HO_W),
      .HOLDOFF (HOLDOFF)
    ) u_holdoff (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (ack_hit[n]),
      .zero_o (ho_zero[n])
    );
  end

  // Pending and overrun next state. The ack clears the channel and beats a
  // same-cycle request; a new overrun beats the clear request.
  always_comb begin
    pending_d = (pending_q & ~ack_hit)
              | (req_event & ~pending_q & ho_zero & ~ack_hit);
    overrun_d = (overrun_q & {NUM_CH{~ovr_clr_i}}) | ovr_set;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pend_o       = pending_q & ~mask_i;
  assign pend_valid_o = |pend_o;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_latch
// Scoreboard bench for irq_pending_latch. The stimulus process drives one
// cycle of inputs at each falling edge, steps a behavioural model of the
// channel rules and pushes the expected outputs; two monitor processes pop
// and compare them (mask path just after the drive, registered state just
// after the rising edge). Build option IRQ_EDGE_DET_EN selects edge mode in
// both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_irq_pending_latch;

  localparam int HOLDOFF = 4;

`ifdef IRQ_EDGE_DET_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] mask = '0;
  logic       ack = 1'b0;
  logic [1:0] ackCode = '0;
  logic       ovrClr = 1'b0;
  logic [2:0] pend;
  logic       pendValid;
  logic [2:0] overrun;

  irq_pending_latch #(
    .HOLDOFF (HOLDOFF),
    .HO_W    (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .mask_i       (mask),
    .pend_o       (pend),
    .pend_valid_o (pendValid),
    .ack_i        (ack),
    .ack_code_i   (ackCode),
    .overrun_o    (overrun),
    .ovr_clr_i    (ovrClr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pend;
    logic [2:0] ovr;
    string      name;
  } expT;

  expT qPre[$];
  expT qPost[$];

  int total = 0;
  int bad   = 0;

  // Behavioural model: per-channel pending flag, remaining hold-off cycles,
  // overrun flag and last request value.
  bit [2:0] mPend;
  bit [2:0] mOvr;
  bit [2:0] mPrev;
  int       mHo[3];

  task automatic modelStep(input bit r, input bit [2:0] rq, input bit a,
                           input bit [1:0] code, input bit clr);
    if (r) begin
      mPend = '0;
      mOvr  = '0;
      mPrev = '0;
      for (int n = 0; n < 3; n++) mHo[n] = 0;
      return;
    end
    for (int n = 0; n < 3; n++) begin
      bit ev;
      bit hit;
      bit ovrNext;
      ev      = EDGE_MODE ? (rq[n] && !mPrev[n]) : rq[n];
      hit     = a && (code != 2'd0) && (int'(code) - 1 == n) && mPend[n];
      ovrNext = mOvr[n] && !clr;
      if (hit) begin
        mPend[n] = 1'b0;
        mHo[n]   = HOLDOFF;
        if (ev) ovrNext = 1'b1;
      end else begin
        if (ev) begin
          if (!mPend[n] && mHo[n] == 0) mPend[n] = 1'b1;
          else if (EDGE_MODE) ovrNext = 1'b1;
        end
        if (mHo[n] > 0) mHo[n] = mHo[n] - 1;
      end
      mOvr[n] = ovrNext;
    end
    mPrev = rq;
  endtask

  // Drive one cycle of inputs and queue what the DUT must show for it.
  task automatic applyStimulus(input string name, input bit r, input bit [2:0] rq,
                               input bit [2:0] m, input bit a, input bit [1:0] code,
                               input bit clr);
    expT e;
    @(negedge clk);
    rst     = r;
    req     = rq;
    mask    = m;
    ack     = a;
    ackCode = code;
    ovrClr  = clr;
    e.pend = mPend & ~m;
    e.ovr  = mOvr;
    e.name = {name, "/comb"};
    qPre.push_back(e);
    modelStep(r, rq, a, code, clr);
    e.pend = mPend & ~m;
    e.ovr  = mOvr;
    e.name = name;
    qPost.push_back(e);
  endtask

  task automatic checkOutput(input expT e, input bit withOvr);
    total++;
    if (pend !== e.pend) begin
      bad++;
      $display("[TB] FAIL %s pend_o got=%b want=%b", e.name, pend, e.pend);
    end
    total++;
    if (pendValid !== (|e.pend)) begin
      bad++;
      $display("[TB] FAIL %s pend_valid_o got=%b want=%b", e.name, pendValid, |e.pend);
    end
    if (withOvr) begin
      total++;
      if (overrun !== e.ovr) begin
        bad++;
        $display("[TB] FAIL %s overrun_o got=%b want=%b", e.name, overrun, e.ovr);
      end
    end
  endtask

  // Mask path monitor: right after new inputs are driven, pend_o must
  // already reflect the new mask over the current pending state.
  always @(negedge clk) begin
    #1;
    if (qPre.size() > 0) checkOutput(qPre.pop_front(), 1'b0);
  end

  // Registered state monitor: just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (qPost.size() > 0) checkOutput(qPost.pop_front(), 1'b1);
  end

  initial begin
    int ack3;
    // Reset and a one-cycle pulse on channels 0 and 2.
    applyStimulus("reset",     1, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("reset2",    1, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("cap101",    0, 3'b101, 3'b000, 0, 2'b00, 0);
    applyStimulus("hold101",   0, 3'b000, 3'b000, 0, 2'b00, 0);
    // Service ch0 so only ch2 remains, then ack ch2 and probe hold-off.
    applyStimulus("ackCh0",    0, 3'b000, 3'b000, 1, 2'b01, 0);
    applyStimulus("ackCh2",    0, 3'b000, 3'b000, 1, 2'b11, 0);
    applyStimulus("ho1",       0, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("ho2",       0, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("hoDrop",    0, 3'b100, 3'b000, 0, 2'b00, 0);
    applyStimulus("ho4",       0, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("rearm",     0, 3'b100, 3'b000, 0, 2'b00, 0);
    applyStimulus("idle",      0, 3'b000, 3'b000, 0, 2'b00, 1);
    // Masking keeps the pending bit; unmasking shows it at once.
    applyStimulus("capCh1",    0, 3'b010, 3'b000, 0, 2'b00, 0);
    applyStimulus("masked",    0, 3'b000, 3'b010, 0, 2'b00, 0);
    applyStimulus("unmasked",  0, 3'b000, 3'b000, 0, 2'b00, 0);
    // Ack for an idle channel does nothing; ch0 captures right after.
    applyStimulus("ackIdle",   0, 3'b000, 3'b000, 1, 2'b01, 0);
    applyStimulus("capCh0",    0, 3'b001, 3'b000, 0, 2'b00, 0);
    // Same-cycle ack and request on ch1, then clear overruns.
    applyStimulus("ackVsReq",  0, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("ackReqCh1", 0, 3'b010, 3'b000, 1, 2'b10, 0);
    applyStimulus("ovrClr",    0, 3'b000, 3'b000, 0, 2'b00, 1);
    // Reset mid-operation with everything pending and hold-off running.
    applyStimulus("fill",      0, 3'b111, 3'b000, 0, 2'b00, 0);
    applyStimulus("fillAck",   0, 3'b000, 3'b000, 1, 2'b01, 0);
    applyStimulus("refill",    0, 3'b001, 3'b000, 0, 2'b00, 0);
    applyStimulus("midReset",  1, 3'b000, 3'b000, 0, 2'b00, 0);
    applyStimulus("postReset", 0, 3'b111, 3'b000, 0, 2'b00, 0);
    applyStimulus("postHold",  0, 3'b000, 3'b000, 0, 2'b00, 0);

    // Randomized traffic; acks are biased towards channels that are pending.
    for (int i = 0; i < 600; i++) begin
      bit [2:0] rq;
      bit [2:0] m;
      bit       a;
      bit [1:0] code;
      rq   = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      m    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      a    = ($urandom_range(0, 2) != 0);
      code = 2'($urandom_range(0, 3));
      ack3 = $urandom_range(0, 3);
      if (ack3 != 0) begin
        for (int n = 2; n >= 0; n--) begin
          if (mPend[n]) begin
            code = 2'(n + 1);
            break;
          end
        end
      end
      applyStimulus("random",
                    ($urandom_range(0, 199) == 0), rq, m, a, code,
                    ($urandom_range(0, 15) == 0));
    end

    applyStimulus("drain", 0, 3'b000, 3'b000, 0, 2'b00, 0);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
